// File: rtl/hdmi_period_scheduler_if.sv
// rtl/hdmi_period_scheduler_if.sv - timing-generator-side and encoder-side signal bundle for hdmi_period_scheduler
interface hdmi_period_scheduler_if;
  logic       hSyncIn;
  logic       vSyncIn;
  logic       deIn;
  logic [7:0] redIn;
  logic [7:0] greenIn;
  logic [7:0] blueIn;
  logic       clearError;
  logic       hSyncOut;
  logic       vSyncOut;
  logic       deOut;
  logic [7:0] redOut;
  logic [7:0] greenOut;
  logic [7:0] blueOut;
  logic [3:0] ctlOut;
  logic [1:0] periodMode;
  logic       scheduleError;

  modport master (
    output hSyncIn, vSyncIn, deIn, redIn, greenIn, blueIn, clearError,
    input  hSyncOut, vSyncOut, deOut, redOut, greenOut, blueOut, ctlOut, periodMode, scheduleError
  );

  modport slave (
    input  hSyncIn, vSyncIn, deIn, redIn, greenIn, blueIn, clearError,
    output hSyncOut, vSyncOut, deOut, redOut, greenOut, blueOut, ctlOut, periodMode, scheduleError
  );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// rtl/hdmi_period_scheduler.sv - delays video by PIPE_DELAY and schedules preamble/guard/video periods
// HDMI_VIDEO_GUARD_EN defined: preamble and guard band emitted; undefined: DVI output (CONTROL/VIDEO only).
module hdmi_period_scheduler #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input logic                  pixelClock,
  input logic                  reset,
  hdmi_period_scheduler_if.slave io
);
  localparam int PIPE_DELAY = PREAMBLE_LEN + GUARD_LEN + 1;
  localparam int CNT_W      = $clog2(PREAMBLE_LEN + GUARD_LEN) + 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  typedef enum logic [1:0] {
    CONTROL  = 2'b00,
    PREAMBLE = 2'b01,
    GUARD    = 2'b10,
    VIDEO    = 2'b11
  } period_t;

  pix_t             pipe [PIPE_DELAY];
  pix_t             outReg;
  logic             deInQ;
  logic             riseQ;
  period_t          state;
  period_t          stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             error;
  logic             errorNext;
  logic             errSet;
  logic             deNext;

  // deInQ resets high so a line already active across reset cannot trigger a preamble
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) pipe[i] <= '0;
      outReg <= '0;
      deInQ  <= 1'b1;
      riseQ  <= 1'b0;
      state  <= CONTROL;
      cnt    <= '0;
      error  <= 1'b0;
    end else begin
      pipe[0] <= '{hs: io.hSyncIn, vs: io.vSyncIn, de: io.deIn,
                   r: io.redIn, g: io.greenIn, b: io.blueIn};
      for (int i = 1; i < PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
      outReg <= pipe[PIPE_DELAY-1];
      deInQ  <= io.deIn;
      riseQ  <= io.deIn & ~deInQ;
      state  <= stateNext;
      cnt    <= cntNext;
      error  <= errorNext;
    end
  end

  assign deNext = pipe[PIPE_DELAY-1].de;

  // The full schedule runs in both builds so error detection is identical in DVI mode
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    errSet    = 1'b0;
    case (state)
      CONTROL: begin
        if (deNext) begin
          stateNext = VIDEO;
          errSet    = 1'b1;
        end else if (riseQ) begin
          stateNext = PREAMBLE;
          cntNext   = '0;
        end
      end
      PREAMBLE: begin
        errSet = riseQ;
        if (cnt == CNT_W'(PREAMBLE_LEN - 1)) begin
          stateNext = GUARD;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      GUARD: begin
        errSet = riseQ;
        if (cnt == CNT_W'(GUARD_LEN - 1)) begin
          stateNext = deNext ? VIDEO : CONTROL;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      VIDEO: begin
        errSet = riseQ;
        if (!deNext) stateNext = CONTROL;
      end
      default: stateNext = CONTROL;
    endcase
    errorNext = errSet | (error & ~io.clearError);
  end

  always_comb begin
`ifdef HDMI_VIDEO_GUARD_EN
    io.periodMode = state;
    io.ctlOut     = (state == PREAMBLE) ? 4'b0001 : 4'b0000;
`else
    io.periodMode = (state == VIDEO) ? VIDEO : CONTROL;
    io.ctlOut     = 4'b0000;
`endif
    io.deOut         = outReg.de & (state == VIDEO);
    io.hSyncOut      = outReg.hs;
    io.vSyncOut      = outReg.vs;
    io.redOut        = io.deOut ? outReg.r : 8'h00;
    io.greenOut      = io.deOut ? outReg.g : 8'h00;
    io.blueOut       = io.deOut ? outReg.b : 8'h00;
    io.scheduleError = error;
  end
endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb/tb_hdmi_period_scheduler.sv - scoreboard bench for hdmi_period_scheduler (HDMI or DVI build via HDMI_VIDEO_GUARD_EN)
module tb_hdmi_period_scheduler;
  logic pixelClock = 1'b0;
  logic reset;
  always #5 pixelClock = ~pixelClock;

  hdmi_period_scheduler_if io();
  hdmi_period_scheduler dut (.pixelClock(pixelClock), .reset(reset), .io(io));

  typedef struct {
    int         e;
    logic [1:0] mode;
    logic [3:0] ctl;
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         edgeCnt = 0;
  int         compared = 0;
  int         mismatched = 0;
  bit         pushEn = 1'b0;
  logic [1:0] expMode [int];
  logic       expErr [int];
  logic       drvH [int];
  logic       drvV [int];
  logic [7:0] drvR [int];
  logic [7:0] drvG [int];
  logic [7:0] drvB [int];

  always @(posedge pixelClock) edgeCnt <= edgeCnt + 1;

  function automatic logic [1:0] mapMode(input logic [1:0] m);
`ifdef HDMI_VIDEO_GUARD_EN
    return m;
`else
    return (m == 2'b11) ? 2'b11 : 2'b00;
`endif
  endfunction

  task automatic fillModes(input int from, input int to, input logic [1:0] m);
    for (int e = from; e <= to; e++) expMode[e] = m;
  endtask

  task automatic fillErr(input int from, input int to);
    for (int e = from; e <= to; e++) expErr[e] = 1'b1;
  endtask

  // Line whose deIn rises at edge b: 8 preamble, 2 guard, then A video outputs
  task automatic lineModes(input int b, input int a);
    fillModes(b + 1, b + 8, 2'b01);
    fillModes(b + 9, b + 10, 2'b10);
    fillModes(b + 11, b + 10 + a, 2'b11);
  endtask

  task automatic pushExp(input int e);
    exp_t x;
    int   d;
    d      = e - 11;
    x.e    = e;
    x.mode = expMode.exists(e) ? mapMode(expMode[e]) : 2'b00;
    x.ctl  = (x.mode == 2'b01) ? 4'b0001 : 4'b0000;
    x.de   = (x.mode == 2'b11);
    x.hs   = drvH.exists(d) ? drvH[d] : 1'b0;
    x.vs   = drvV.exists(d) ? drvV[d] : 1'b0;
    x.r    = (x.de && drvR.exists(d)) ? drvR[d] : 8'h00;
    x.g    = (x.de && drvG.exists(d)) ? drvG[d] : 8'h00;
    x.b    = (x.de && drvB.exists(d)) ? drvB[d] : 8'h00;
    x.err  = expErr.exists(e) ? expErr[e] : 1'b0;
    sb.push_back(x);
  endtask

  task automatic pushZero(input int e);
    exp_t x;
    x = '{e: e, mode: 2'b00, ctl: 4'b0000, de: 1'b0, hs: 1'b0, vs: 1'b0,
          r: 8'h00, g: 8'h00, b: 8'h00, err: 1'b0};
    sb.push_back(x);
  endtask

  task automatic step(input logic h, input logic v, input logic d,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic clr);
    int e;
    e = edgeCnt + 1;
    io.hSyncIn = h;  io.vSyncIn = v;  io.deIn = d;
    io.redIn = r;    io.greenIn = g;  io.blueIn = b;
    io.clearError = clr;
    drvH[e] = h; drvV[e] = v; drvR[e] = r; drvG[e] = g; drvB[e] = b;
    if (pushEn) pushExp(e + 11);
    @(posedge pixelClock);
    #1;
  endtask

  task automatic runLine(input int nBlank, input int nActive, input logic [7:0] base, input int clrAt);
    logic [7:0] rr;
    for (int i = 0; i < nBlank; i++)
      step(nBlank >= 8 && i >= 1 && i <= 4, nBlank >= 100 && i == 2, 1'b0,
           8'h00, 8'h00, 8'h00, (edgeCnt + 1) == clrAt);
    for (int k = 0; k < nActive; k++) begin
      rr = 8'(base * (k + 1));
      step(1'b0, 1'b0, 1'b1, rr, rr ^ 8'hA5, ~rr, (edgeCnt + 1) == clrAt);
    end
  endtask

  always @(negedge pixelClock) begin
    exp_t        x;
    logic [33:0] act;
    logic [33:0] want;
    while (sb.size() > 0 && sb[0].e <= edgeCnt) begin
      x = sb.pop_front();
      compared++;
      act  = {io.periodMode, io.ctlOut, io.deOut, io.hSyncOut, io.vSyncOut,
              io.redOut, io.greenOut, io.blueOut, io.scheduleError};
      want = {x.mode, x.ctl, x.de, x.hs, x.vs, x.r, x.g, x.b, x.err};
      if (x.e < edgeCnt) begin
        mismatched++;
        $display("FAIL stale@edge%0d: checked at edge %0d, required edge %0d", x.e, edgeCnt, x.e);
      end else if (act !== want) begin
        mismatched++;
        $display("FAIL outputs@edge%0d: got %h required %h {mode,ctl,de,hs,vs,r,g,b,err}",
                 x.e, act, want);
      end
    end
  end

  initial begin
    int b;
    int b1;
    reset = 1'b1;
    io.hSyncIn = 1'b0; io.vSyncIn = 1'b0; io.deIn = 1'b0;
    io.redIn = 8'h00; io.greenIn = 8'h00; io.blueIn = 8'h00;
    io.clearError = 1'b0;
    repeat (3) @(posedge pixelClock);
    #1;
    reset = 1'b0;
    for (int e = 4; e <= 14; e++) pushExp(e);
    pushEn = 1'b1;

    // 720-pixel line after 138 blanking cycles
    b = edgeCnt + 1 + 138;
    lineModes(b, 720);
    runLine(138, 720, 8'h01, -1);

    // 3-pixel run: 0x11, 0x22, 0x33
    b = edgeCnt + 1 + 20;
    lineModes(b, 3);
    runLine(20, 3, 8'h11, -1);

    // Reset asserted during the guard band
    b = edgeCnt + 1 + 20;
    fillModes(b + 1, b + 8, 2'b01);
    for (int i = 0; i < 20; i++) begin
      if (edgeCnt + 1 >= b - 2) pushEn = 1'b0;
      step(i >= 1 && i <= 4, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1, 8'(8'h40 + k), 8'h01, 8'h02, 1'b0);
    reset = 1'b1;
    for (int e = b + 9; e <= b + 22; e++) pushZero(e);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    reset = 1'b0;
    pushEn = 1'b1;
    b = edgeCnt + 1 + 15;
    lineModes(b, 30);
    runLine(15, 30, 8'h07, -1);

    // Short blanking: errors, VIDEO without preamble, clear losing to a new error, then clear
    b1 = edgeCnt + 1 + 15;
    lineModes(b1, 20);
    fillModes(b1 + 36, b1 + 55, 2'b11);
    fillModes(b1 + 61, b1 + 80, 2'b11);
    fillErr(b1 + 26, b1 + 89);
    runLine(15, 20, 8'h03, -1);
    runLine(5, 20, 8'h50, -1);
    runLine(5, 20, 8'h90, b1 + 51);
    runLine(25, 0, 8'h00, b1 + 90);
    runLine(15, 0, 8'h00, -1);

    repeat (13) @(posedge pixelClock);
    @(negedge pixelClock);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
